// File: rtl/bcd_disp_pkg.sv
// Shared constants for the six-digit BCD display scanner.
// Holds the digit count, the active-low seven-segment glyphs ({g,f,e,d,c,b,a}),
// the all-off anode pattern and a helper that builds a one-hot active-low
// anode word from a digit index.
package bcd_disp_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = 6'b111111;

    // Active-low one-hot anode word selecting digit idx.
    function automatic logic [NUM_DIGITS-1:0] an_select(input logic [2:0] idx);
        an_select = ~(6'b000001 << idx);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to seven-segment decoder.
// Ports:
//   i_nibble  4-bit digit value
//   o_seg     active-low segments {g,f,e,d,c,b,a}; values above 9 give a dash
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd6_display_scan.sv
// Six-digit multiplexed BCD display scanner with leading-zero blanking.
// A LOAD strobe captures six packed BCD digits into a shadow register; a
// prescaler divides the clock into digit slots and a digit index walks 0..5,
// driving one active-low anode and the matching active-low segment pattern.
// Ports:
//   i_clk       clock, rising edge
//   i_clr_n     synchronous active-low reset
//   i_ena       display enable; 0 blanks all anodes and holds the scan
//   i_load      one-cycle capture strobe for i_bcd_in
//   i_bcd_in    six BCD digits, [3:0] least significant
//   i_blank_en  leading-zero blanking enable
//   o_ack       one-cycle pulse after each capture
//   o_err       sticky: shadow holds a nibble above 9
//   o_an        active-low one-hot digit anodes
//   o_seg       active-low segments {g,f,e,d,c,b,a}
module bcd6_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter bit BLANK_DEF = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_clr_n,
    input  logic        i_ena,
    input  logic        i_load,
    input  logic [23:0] i_bcd_in,
    input  logic        i_blank_en,
    output logic        o_ack,
    output logic        o_err,
    output logic [5:0]  o_an,
    output logic [6:0]  o_seg
);

    localparam int               CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic             r_live;    // set by the first tick after reset; outputs stay dark until then
    logic [23:0]      r_shadow;
    logic             r_blank;
    logic             r_ack;
    logic             r_err;
    logic [5:0]       r_an;
    logic [6:0]       r_seg;

    logic             w_tick;
    logic             w_bad_in;
    logic [2:0]       w_msd;
    logic [3:0]       w_nibble;
    logic [6:0]       w_glyph;
    logic             w_blanked;

    assign w_tick = i_ena && (r_cnt == CNT_LAST);

    always_comb begin
        w_bad_in = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i_bcd_in[4*i +: 4] > 4'd9) w_bad_in = 1'b1;
        end
    end

    // Most significant nonzero digit of the shadow; an all-zero value leaves
    // it at 0 so digit 0 is never blanked. Non-BCD nibbles count as nonzero.
    always_comb begin
        w_msd = 3'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (r_shadow[4*i +: 4] != 4'd0) w_msd = 3'(i);
        end
    end

    assign w_nibble  = r_shadow[{r_idx, 2'b00} +: 4];
    assign w_blanked = r_blank && (r_idx > w_msd);

    bcd_to_seg7 u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_cnt    <= '0;
            r_idx    <= 3'd0;
            r_live   <= 1'b0;
            r_shadow <= 24'd0;
            r_blank  <= BLANK_DEF;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_an     <= AN_OFF;
            r_seg    <= SEG_OFF;
        end else begin
            r_blank <= i_blank_en;
            r_ack   <= i_load;
            if (i_load) begin
                r_shadow <= i_bcd_in;
                r_err    <= w_bad_in;
            end

            if (i_ena) begin
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            end

            // The first tick only lights digit 0; later ticks advance the index.
            if (w_tick) begin
                if (!r_live) begin
                    r_live <= 1'b1;
                end else begin
                    r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
                end
            end

            r_an  <= (r_live && i_ena) ? an_select(r_idx) : AN_OFF;
            r_seg <= (!r_live || w_blanked) ? SEG_OFF : w_glyph;
        end
    end

    assign o_ack = r_ack;
    assign o_err = r_err;
    assign o_an  = r_an;
    assign o_seg = r_seg;

endmodule

// File: tb/tb_bcd6_display_scan.sv
module tb_bcd6_display_scan;

    localparam int SCAN_DIV  = 4;
    localparam bit BLANK_DEF = 1'b1;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        ena;
    logic        load;
    logic [23:0] bcd;
    logic        blank_en;
    logic        ack;
    logic        err;
    logic [5:0]  an;
    logic [6:0]  seg;

    always #5 clk = ~clk;

    bcd6_display_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_DEF (BLANK_DEF)
    ) dut (
        .i_clk      (clk),
        .i_clr_n    (clr_n),
        .i_ena      (ena),
        .i_load     (load),
        .i_bcd_in   (bcd),
        .i_blank_en (blank_en),
        .o_ack      (ack),
        .o_err      (err),
        .o_an       (an),
        .o_seg      (seg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_cnt;
    int          m_idx;
    bit          m_live;
    bit          m_blank;
    logic [23:0] m_shadow;
    logic        m_ack;
    logic        m_err;
    logic [5:0]  m_an;
    logic [6:0]  m_seg;

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic int digit_of(input logic [23:0] v, input int i);
        return int'((v >> (4 * i)) & 24'hF);
    endfunction

    function automatic logic [6:0] expect_seg(input logic [23:0] v, input int idx, input bit blank);
        int msd = 0;
        for (int i = 0; i < 6; i++) if (digit_of(v, i) != 0) msd = i;
        if (blank && idx > msd) return 7'h7F;
        return glyph(digit_of(v, idx));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_live = 0; m_blank = BLANK_DEF;
        m_shadow = 24'h0; m_ack = 0; m_err = 0; m_an = 6'h3F; m_seg = 7'h7F;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_step();
        bit any_bad;
        bit tick;
        if (!clr_n) begin
            model_reset();
            return;
        end
        m_an  = (m_live && ena) ? (6'h3F & ~(6'h01 << m_idx)) : 6'h3F;
        m_seg = m_live ? expect_seg(m_shadow, m_idx, m_blank) : 7'h7F;
        m_ack = load;
        if (load) begin
            m_shadow = bcd;
            any_bad = 0;
            for (int i = 0; i < 6; i++) if (digit_of(bcd, i) > 9) any_bad = 1;
            m_err = any_bad;
        end
        tick = ena && (m_cnt == SCAN_DIV - 1);
        if (ena) m_cnt = (m_cnt + 1) % SCAN_DIV;
        if (tick) begin
            if (m_live) m_idx = (m_idx + 1) % 6;
            else        m_live = 1;
        end
        m_blank = blank_en;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("ack", ack, m_ack);
        check("err", err, m_err);
        check("an",  an,  m_an);
        check("seg", seg, m_seg);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [23:0] v);
        load = 1'b1;
        bcd  = v;
        cycle();
        load = 1'b0;
    endtask

    function automatic logic [23:0] rand_bcd();
        logic [23:0] v = 24'h0;
        int k = $urandom_range(0, 6);
        for (int i = 0; i < k; i++) begin
            int nib = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            v = v | (24'(nib) << (4 * i));
        end
        return v;
    endfunction

    initial begin
        clr_n = 1'b0; ena = 1'b0; load = 1'b0; bcd = 24'h0; blank_en = 1'b1;
        model_reset();
        cycles(3);
        check("reset_an", an, 6'h3F);
        check("reset_seg", seg, 7'h7F);

        clr_n = 1'b1; ena = 1'b1;
        cycles(32);

        do_load(24'h123456);
        cycles(28);

        do_load(24'h000042);
        cycles(28);
        do_load(24'h000000);
        cycles(28);
        blank_en = 1'b0;
        cycles(28);
        blank_en = 1'b1;

        do_load(24'h00A001);
        check("err_set", err, 1'b1);
        cycles(28);
        do_load(24'h000001);
        check("err_clear", err, 1'b0);
        cycles(4);

        // drop enable while digit 3 is shown
        for (int i = 0; i < 40 && !(m_live && m_idx == 3); i++) cycle();
        check("reached_idx3", 32'(m_idx), 32'd3);
        ena = 1'b0;
        cycles(10);
        ena = 1'b1;
        cycles(30);

        // reset wins over a simultaneous load
        clr_n = 1'b0; load = 1'b1; bcd = 24'h999999;
        cycle();
        check("rst_load_ack", ack, 1'b0);
        load = 1'b0; clr_n = 1'b1;
        cycles(30);

        // load coincident with a tick
        for (int i = 0; i < 10 && !(m_live && m_cnt == SCAN_DIV - 1); i++) cycle();
        do_load(24'h654321);
        cycles(12);

        // reset in mid scan
        cycles(7);
        clr_n = 1'b0;
        cycle();
        clr_n = 1'b1;
        cycles(20);

        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(0, 7) == 0);
            bcd  = load ? rand_bcd() : 24'(($urandom() & 32'hFFFFFF));
            if ($urandom_range(0, 9) == 0) ena = ~ena;
            if ($urandom_range(0, 29) == 0) blank_en = ~blank_en;
            clr_n = ($urandom_range(0, 199) != 0);
            cycle();
        end
        load = 1'b0; clr_n = 1'b1;
        cycles(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd6_display_scan.md
BCD6_DISPLAY_SCAN -- requirements
Module: bcd6_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning CLK cycles per digit slot (minimum 2).
REQ-002 SHALL have parameter BLANK_DEF, default 1, meaning the leading-zero blanking state after reset.
REQ-003 CLK  input  1  single clock; all logic updates on the rising edge.
REQ-004 CLR_N  input  1  reset, synchronous and active-low.
REQ-005 ENA  input  1  display enable; 0 turns all digits off and holds the scan.
REQ-006 LOAD  input  1  one-cycle strobe; capture BCD_IN.
REQ-007 BCD_IN  input  24  six packed BCD digits; [3:0] is least significant, [23:20] is most significant.
REQ-008 BLANK_EN  input  1  leading-zero blanking enable; sampled every cycle.
REQ-009 ACK  output  1  one-cycle pulse confirming a capture.
REQ-010 ERR  output  1  sticky flag: latched data holds a non-BCD nibble.
REQ-011 AN  output  6  digit anodes, active-low, one-hot.
REQ-012 SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-013 SHALL capture BCD_IN into a 24-bit shadow register on any rising edge with LOAD=1 and CLR_N=1, regardless of ENA.
REQ-014 SHALL assert ACK for exactly the cycle after each capture; back-to-back LOADs SHALL give back-to-back ACKs, and the last capture wins.
REQ-015 SHALL set ERR on capture if any nibble exceeds 9, and clear ERR on a capture in which all nibbles are 0-9.
REQ-016 SHALL run a prescaler 0..SCAN_DIV-1 while ENA=1, wrapping to 0 and producing a one-cycle tick on the terminal count; the prescaler SHALL hold its value while ENA=0.
REQ-017 SHALL advance the digit index 0,1,2,3,4,5,0 on each tick; index 5 SHALL wrap to 0.
REQ-018 SHALL register AN and SEG, updating them one cycle after any change to the index or shadow register.
REQ-019 AN SHALL drive low only bit [index] when ENA=1, and SHALL be 6'b111111 when ENA=0, effective the cycle after ENA changes.
REQ-020 SEG SHALL show the standard 0-9 glyphs; a nibble above 9 SHALL show a dash, 7'b0111111.
REQ-021 With BLANK_EN=1, any digit above the most significant nonzero digit SHALL show SEG=7'b1111111 while its AN remains active; digit 0 SHALL never be blanked, so a value of 0 shows "0".
REQ-022 A non-BCD nibble SHALL count as nonzero when determining blanking.
REQ-023 If LOAD and a tick occur in the same cycle, the next AN/SEG SHALL show the new index using the new data.
REQ-024 SEG SHALL be a pure function of the shadow register, index and BLANK_EN; no combinational path SHALL exist from BCD_IN to SEG.

Reset
REQ-025 When CLR_N=0 at a rising edge, the block SHALL clear prescaler=0, index=0, shadow=0, ACK=0, ERR=0, AN=6'b111111, SEG=7'b1111111, and set blanking to BLANK_DEF.
REQ-026 Reset SHALL override a simultaneous LOAD: no capture and no ACK.
REQ-027 A reset mid-scan SHALL restart the scan at index 0 with a full SCAN_DIV period.

Structure
REQ-028 A shared package bcd_disp_pkg SHALL hold NUM_DIGITS=6, the segment glyph constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF) and the AN_OFF constant.
REQ-029 A combinational sub-module bcd_to_seg7 (4-bit nibble in, 7-bit active-low segments out, dash for values above 9) SHALL be instantiated once, on the muxed digit.
REQ-030 Prescaler width SHALL be $clog2(SCAN_DIV); the digit index SHALL be 3 bits.

Verification (SCAN_DIV=4)
REQ-031 Reset, then ENA=1 -> AN=111111 and SEG=1111111 until the first tick; AN=111110 one cycle after the first tick; after 6 further ticks AN cycles 111101, 111011, 110111, 101111, 011111, 111110.
REQ-032 LOAD with BCD_IN=24'h123456 -> ACK high for the next cycle only; digit 0 shows 6 (SEG=0000010) and digit 5 shows 1 (SEG=1111001).
REQ-033 BLANK_EN=1, LOAD 24'h000042 -> digits 2-5 show SEG=1111111, digit 1 shows 4, digit 0 shows 2; LOAD 24'h000000 -> digit 0 shows 0 (1000000) and all other digits are blank.
REQ-034 LOAD 24'h00A001 -> ERR=1 and digit 3 shows a dash (0111111); a following LOAD 24'h000001 -> ERR=0.
REQ-035 ENA dropped to 0 at index 3 for 10 cycles -> AN=111111 throughout; on ENA=1 the scan resumes at index 3 with the held prescaler value.
REQ-036 CLR_N=0 in the same cycle as LOAD=1 -> no ACK and shadow=0; LOAD aligned with a tick -> the new digit appears at the new index.
